dice_rf_read_arbiter: RTL

DICE_RF_READ_ARBITER -- requirements
Module: dice_rf_read_arbiter

---
 rtl/dice_rf_pkg.sv | 22 ++
 rtl/dice_rr_arbiter.sv | 42 ++++
 rtl/dice_rf_read_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/dice_rf_pkg.sv
// Shared types and helpers for the banked register-file read arbiter.
// Bank/row split is low-order interleaved; pipe entries carry one grant per bank.
package dice_rf_pkg;

  localparam int MAX_IDX_W = 8;
  localparam int MAX_TAG_W = 16;

  typedef struct packed {
    logic                 vld;
    logic [MAX_IDX_W-1:0] idx;
    logic [MAX_TAG_W-1:0] tag;
  } pipe_entry_t;

  function automatic logic [31:0] bank_of(input logic [31:0] reg_idx, input int bank_bits);
    return reg_idx & ((32'd1 << bank_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] row_of(input logic [31:0] reg_idx, input int bank_bits);
    return reg_idx >> bank_bits;
  endfunction

endpackage

// File: rtl/dice_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from an internal pointer, 0 cycles.
// The pointer moves past the winner only when advance is asserted.
module dice_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= IDX_W'((int'(grant_idx) + 1) % NUM_REQ);
    end
  end

endmodule

// File: rtl/dice_rf_read_arbiter.sv
// Banked register-file read arbiter: per-bank round-robin grant, read issued same cycle,
// response returned exactly one cycle later; no response backpressure.
module dice_rf_read_arbiter
  import dice_rf_pkg::*;
#(
  parameter int NUM_BANK  = 4,
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 512,
  parameter int NUM_REQ   = 4,
  parameter int TAG_WIDTH = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BANK_BITS  = $clog2(NUM_BANK),
  parameter int REG_WIDTH  = ADDR_WIDTH + BANK_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*REG_WIDTH-1:0]   req_reg,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_BANK-1:0]            rf_rd_en,
  output logic [NUM_BANK*ADDR_WIDTH-1:0] rf_rd_addr,
  input  logic [NUM_BANK*WIDTH-1:0]      rf_rd_data,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [NUM_REQ*WIDTH-1:0]       rsp_data,
  output logic [NUM_REQ*TAG_WIDTH-1:0]   rsp_tag
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [BANK_BITS-1:0]  req_bank       [NUM_REQ];
  logic [ADDR_WIDTH-1:0] req_row        [NUM_REQ];
  logic [NUM_REQ-1:0]    bank_req       [NUM_BANK];
  logic [NUM_REQ-1:0]    bank_grant     [NUM_BANK];
  logic [IDX_W-1:0]      bank_grant_idx [NUM_BANK];
  pipe_entry_t           pipe           [NUM_BANK];

  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      req_bank[r] = BANK_BITS'(bank_of(32'(req_reg[r*REG_WIDTH +: REG_WIDTH]), BANK_BITS));
      req_row[r]  = ADDR_WIDTH'(row_of(32'(req_reg[r*REG_WIDTH +: REG_WIDTH]), BANK_BITS));
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        bank_req[b][r] = req_valid[r] && (req_bank[r] == BANK_BITS'(b));
      end
    end
  end

  // Pointers only move on a real grant, so a requester that drops out leaves no trace.
  for (genvar gb = 0; gb < NUM_BANK; gb++) begin : g_bank
    dice_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
    ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (bank_req[gb]),
      .advance   (rf_rd_en[gb]),
      .grant     (bank_grant[gb]),
      .grant_idx (bank_grant_idx[gb])
    );
  end

  always_comb begin
    req_ready  = '0;
    rf_rd_en   = '0;
    rf_rd_addr = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      req_ready = req_ready | bank_grant[b];
      rf_rd_en[b] = |bank_grant[b];
      if (rf_rd_en[b]) begin
        rf_rd_addr[b*ADDR_WIDTH +: ADDR_WIDTH] = req_row[bank_grant_idx[b]];
      end
    end
  end

  // Flush only kills the response; the read itself and the pointer advance still happen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        pipe[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        pipe[b].vld <= rf_rd_en[b] && !flush;
        pipe[b].idx <= MAX_IDX_W'(bank_grant_idx[b]);
        pipe[b].tag <= MAX_TAG_W'(req_tag[bank_grant_idx[b]*TAG_WIDTH +: TAG_WIDTH]);
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_tag   = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        if (pipe[b].vld && (pipe[b].idx == MAX_IDX_W'(r))) begin
          rsp_valid[r]                    = 1'b1;
          rsp_data[r*WIDTH +: WIDTH]      = rf_rd_data[b*WIDTH +: WIDTH];
          rsp_tag[r*TAG_WIDTH +: TAG_WIDTH] = TAG_WIDTH'(pipe[b].tag);
        end
      end
    end
  end

endmodule
